// File: rtl/axi4_lite_slave_responder_pkg.sv
// Shared bus widths, response encodings and FSM state constants for the
// AXI4-Lite register-file responder.
package axi4_lite_slave_responder_pkg;

    localparam int AXI_ADDRESS_WIDTH = 32;
    localparam int AXI_DATA_WIDTH    = 32;
    localparam int AXI_DELAY_WIDTH   = 5;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_enum;

    typedef enum logic [1:0] {
        RRESP_OKAY   = 2'b00,
        RRESP_EXOKAY = 2'b01,
        RRESP_SLVERR = 2'b10,
        RRESP_DECERR = 2'b11
    } rresp_enum;

    typedef enum logic [1:0] {
        DEC_OKAY   = 2'b00,
        DEC_SLVERR = 2'b10,
        DEC_DECERR = 2'b11
    } dec_result_t;

    typedef logic [0:0] write_fsm_state_t;
    typedef logic [0:0] read_fsm_state_t;

    localparam write_fsm_state_t W_COLLECT = 1'b0;
    localparam write_fsm_state_t W_RESP    = 1'b1;
    localparam read_fsm_state_t  R_IDLE    = 1'b0;
    localparam read_fsm_state_t  R_RESP    = 1'b1;

    function automatic bresp_enum to_bresp(input dec_result_t dec);
        case (dec)
            DEC_SLVERR: return BRESP_SLVERR;
            DEC_DECERR: return BRESP_DECERR;
            default:    return BRESP_OKAY;
        endcase
    endfunction

    function automatic rresp_enum to_rresp(input dec_result_t dec);
        case (dec)
            DEC_SLVERR: return RRESP_SLVERR;
            DEC_DECERR: return RRESP_DECERR;
            default:    return RRESP_OKAY;
        endcase
    endfunction

endpackage

// File: rtl/axi4_lite_ready_delay.sv
// Per-channel ready generator: ready rises once valid has waited cfg cycles,
// and is suppressed while the channel's beat is already held.
module axi4_lite_ready_delay
    import axi4_lite_slave_responder_pkg::*;
#(
    parameter int DELAY_WIDTH = AXI_DELAY_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic                   held,
    input  logic [DELAY_WIDTH-1:0] cfg,
    output logic                   ready
);

    logic [DELAY_WIDTH-1:0] cnt;

    // Ready is independent of valid, so a zero delay accepts on the first valid cycle.
    assign ready = !reset && !held && (cnt >= cfg);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (valid && ready) begin
            cnt <= '0;
        end else if (valid && (cnt != '1)) begin
            cnt <= cnt + DELAY_WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi4_lite_slave_responder.sv
// AXI4-Lite slave backed by a word-addressed register file, with independent
// write/read channels and programmable per-channel ready delays.
module axi4_lite_slave_responder
    import axi4_lite_slave_responder_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH = AXI_ADDRESS_WIDTH,
    parameter int                         DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter int                         DELAY_WIDTH   = AXI_DELAY_WIDTH,
    parameter int                         NUM_REGS      = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = '0
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [ADDRESS_WIDTH-1:0]   awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [ADDRESS_WIDTH-1:0]   araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [DELAY_WIDTH-1:0]     cfg_awready_delay,
    input  logic [DELAY_WIDTH-1:0]     cfg_wready_delay,
    input  logic [DELAY_WIDTH-1:0]     cfg_arready_delay
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic dec_result_t decode(input logic [ADDRESS_WIDTH-1:0] addr);
        logic [ADDRESS_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        if ((addr < BASE_ADDR) || ((offset >> 2) >= ADDRESS_WIDTH'(NUM_REGS))) begin
            return DEC_DECERR;
        end else if (offset[1:0] != 2'b00) begin
            return DEC_SLVERR;
        end
        return DEC_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] reg_index(input logic [ADDRESS_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    write_fsm_state_t         w_state;
    read_fsm_state_t          r_state;
    logic                     aw_held;
    logic                     w_held;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_W-1:0]        wstrb_q;

    logic                     aw_hs;
    logic                     w_hs;
    logic                     ar_hs;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] addr_eff;
    logic [DATA_WIDTH-1:0]    wdata_eff;
    logic [STRB_W-1:0]        wstrb_eff;
    dec_result_t              wr_dec;
    dec_result_t              rd_dec;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         rd_idx;
    logic                     unused_prot;

    assign unused_prot = ^{awprot, arprot};

    axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH)) u_aw_delay (
        .clk(aclk), .reset(areset), .valid(awvalid), .held(aw_held),
        .cfg(cfg_awready_delay), .ready(awready)
    );

    axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH)) u_w_delay (
        .clk(aclk), .reset(areset), .valid(wvalid), .held(w_held),
        .cfg(cfg_wready_delay), .ready(wready)
    );

    axi4_lite_ready_delay #(.DELAY_WIDTH(DELAY_WIDTH)) u_ar_delay (
        .clk(aclk), .reset(areset), .valid(arvalid), .held(r_state == R_RESP),
        .cfg(cfg_arready_delay), .ready(arready)
    );

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // A beat arriving on this edge counts as held, giving one-cycle AW/W-to-B latency.
    assign addr_eff  = aw_held ? aw_addr_q : awaddr;
    assign wdata_eff = w_held ? wdata_q : wdata;
    assign wstrb_eff = w_held ? wstrb_q : wstrb;
    assign commit    = (w_state == W_COLLECT) && (aw_held || aw_hs) && (w_held || w_hs);

    assign wr_dec = decode(addr_eff);
    assign wr_idx = reg_index(addr_eff);
    assign rd_dec = decode(araddr);
    assign rd_idx = reg_index(araddr);

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state   <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid    <= 1'b0;
            bresp     <= BRESP_OKAY;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (aw_hs) begin
                        aw_held   <= 1'b1;
                        aw_addr_q <= awaddr;
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                    end
                    if (commit) begin
                        bvalid  <= 1'b1;
                        bresp   <= to_bresp(wr_dec);
                        w_state <= W_RESP;
                    end
                end
                default: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        w_state <= W_COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && (wr_dec == DEC_OKAY)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_eff[b]) begin
                    regs[wr_idx][8*b +: 8] <= wdata_eff[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the array before any same-edge write lands, so they see the old value.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rresp   <= RRESP_OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rvalid  <= 1'b1;
                        rresp   <= to_rresp(rd_dec);
                        rdata   <= (rd_dec == DEC_OKAY) ? regs[rd_idx] : '0;
                        r_state <= R_RESP;
                    end
                end
                default: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_responder.sv
// Self-checking bench for axi4_lite_slave_responder: directed scenarios plus
// randomized traffic checked against a simple register-array model.
module tb_axi4_lite_slave_responder;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [4:0]  cfg_awready_delay = '0;
    logic [4:0]  cfg_wready_delay = '0;
    logic [4:0]  cfg_arready_delay = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] model_regs [16];

    axi4_lite_slave_responder dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .cfg_awready_delay(cfg_awready_delay), .cfg_wready_delay(cfg_wready_delay),
        .cfg_arready_delay(cfg_arready_delay)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model: 16 words at byte address 0, 4 bytes per word.
    function automatic logic [1:0] model_resp(input logic [31:0] addr);
        if (addr >= 32'd64) return 2'b11;
        if ((addr % 4) != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] word;
        if (model_resp(addr) != 2'b00) return;
        word = model_regs[addr / 4];
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
        end
        model_regs[addr / 4] = word;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_off, input int w_off, output logic [1:0] resp,
                            output int start_c, output int aw_c, output int w_c, output int b_c,
                            output bit timeout);
        bit aw_done, w_done, b_done;
        aw_done = 0; w_done = 0; b_done = 0; timeout = 0;
        resp = '0; aw_c = -1; w_c = -1; b_c = -1;
        @(posedge aclk); #1;
        start_c = cyc;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (!aw_done && k == aw_off) awvalid = 1'b1;
            if (!w_done && k == w_off) wvalid = 1'b1;
            @(negedge aclk);
            if (awvalid && awready) begin aw_done = 1; aw_c = cyc; end
            if (wvalid && wready) begin w_done = 1; w_c = cyc; end
            if (bvalid && b_c < 0) begin b_c = cyc; resp = bresp; end
            if (bvalid && bready) b_done = 1;
            @(posedge aclk); #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            if (b_done) break;
        end
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        if (!b_done) timeout = 1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int start_c, output int ar_c, output int r_c, output bit timeout);
        bit done;
        done = 0; timeout = 0; ar_c = -1; r_c = -1; data = '0; resp = '0;
        @(posedge aclk); #1;
        start_c = cyc;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            if (arvalid && arready) ar_c = cyc;
            if (rvalid && r_c < 0) begin r_c = cyc; data = rdata; resp = rresp; end
            if (rvalid && rready) done = 1;
            @(posedge aclk); #1;
            if (ar_c >= 0) arvalid = 1'b0;
            if (done) break;
        end
        rready = 1'b0; arvalid = 1'b0;
        if (!done) timeout = 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            checks++;
            if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 ||
                rresp !== 2'b00 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: rdy/valid=%b bresp=%b rresp=%b rdata=%h, required all zero",
                         {awready, wready, arready, bvalid, rvalid}, bresp, rresp, rdata);
            end
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        model_clear();
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b, required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] data; int s, ac, wc, bc, rc; bit to;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, resp, s, ac, wc, bc, to);
        model_write(32'h4, 32'hDEADBEEF, 4'hF);
        checks++;
        if (to || ac != s || wc != s || bc != s + 1 || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_write: aw=%0d w=%0d b=%0d resp=%b to=%0d, required aw=w=%0d b=%0d resp=00",
                     ac - s, wc - s, bc - s, resp, to, 0, 1);
        end
        do_read(32'h4, data, resp, s, ac, rc, to);
        checks++;
        if (to || ac != s || rc != ac + 1 || data !== model_regs[1] || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read: ar=%0d r=%0d data=%h resp=%b, required ar=0 r=1 data=%h resp=00",
                     ac - s, rc - s, data, resp, model_regs[1]);
        end
    endtask

    task automatic test_aw_delay();
        logic [1:0] resp; int s, ac, wc, bc; bit to;
        @(posedge aclk); #1;
        cfg_awready_delay = 5'd3; cfg_wready_delay = 5'd0;
        do_write(32'h0, 32'hA5A5_0001, 4'hF, 2, 0, resp, s, ac, wc, bc, to);
        model_write(32'h0, 32'hA5A5_0001, 4'hF);
        checks++;
        if (to || wc != s || ac != s + 5 || bc != ac + 1 || resp !== 2'b00) begin
            errors++;
            $display("FAIL aw_delay: w=%0d aw=%0d b=%0d resp=%b, required w=0 aw=5 b=6 resp=00",
                     wc - s, ac - s, bc - s, resp);
        end
        cfg_awready_delay = 5'd0;
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] data; int s, ac, wc, bc; bit to;
        do_write(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, resp, s, ac, wc, bc, to);
        model_write(32'h8, 32'hFFFFFFFF, 4'hF);
        do_write(32'h8, 32'h12345678, 4'b0101, 0, 0, resp, s, ac, wc, bc, to);
        model_write(32'h8, 32'h12345678, 4'b0101);
        do_read(32'h8, data, resp, s, ac, bc, to);
        checks++;
        if (to || data !== 32'hFF34FF78 || data !== model_regs[2]) begin
            errors++;
            $display("FAIL strobe_merge: got %h, required %h", data, 32'hFF34FF78);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [31:0] data; int s, ac, wc, bc; bit to;
        do_write(32'h40, 32'h0BAD0BAD, 4'hF, 0, 0, resp, s, ac, wc, bc, to);
        checks++;
        if (to || resp !== 2'b11) begin
            errors++;
            $display("FAIL write_decerr: resp=%b, required 11", resp);
        end
        do_write(32'h5, 32'h0BAD0BAD, 4'hF, 0, 0, resp, s, ac, wc, bc, to);
        checks++;
        if (to || resp !== 2'b10) begin
            errors++;
            $display("FAIL write_slverr: resp=%b, required 10", resp);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), data, resp, s, ac, bc, to);
            checks++;
            if (to || data !== model_regs[i] || resp !== 2'b00) begin
                errors++;
                $display("FAIL regs_after_error[%0d]: got %h/%b, required %h/00", i, data, resp, model_regs[i]);
            end
        end
        do_read(32'h6, data, resp, s, ac, bc, to);
        checks++;
        if (to || resp !== 2'b10 || data !== 32'h0) begin
            errors++;
            $display("FAIL read_slverr: got %h/%b, required 00000000/10", data, resp);
        end
        do_read(32'h44, data, resp, s, ac, bc, to);
        checks++;
        if (to || resp !== 2'b11 || data !== 32'h0) begin
            errors++;
            $display("FAIL read_decerr: got %h/%b, required 00000000/11", data, resp);
        end
    endtask

    task automatic test_backpressure();
        @(posedge aclk); #1;
        awaddr = 32'h48; wdata = 32'h1111_2222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b11 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold[%0d]: bvalid=%b bresp=%b awready=%b wready=%b, required 1 11 0 0",
                         i, bvalid, bresp, awready, wready);
            end
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_release: bvalid=%b awready=%b wready=%b, required 0 1 1", bvalid, awready, wready);
        end
        araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            checks++;
            if (rvalid !== 1'b1 || rdata !== model_regs[1] || rresp !== 2'b00 || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b, required 1 %h 00 0",
                         i, rvalid, rdata, rresp, arready, model_regs[1]);
            end
            @(posedge aclk); #1;
        end
        rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++;
            $display("FAIL r_release: rvalid=%b arready=%b, required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] wresp, rresp_v; logic [31:0] data, old_val; int s1, s2, ac, wc, bc, arc, rc; bit to1, to2;
        old_val = model_regs[4];
        fork
            do_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, wresp, s1, ac, wc, bc, to1);
            do_read(32'h10, data, rresp_v, s2, arc, rc, to2);
        join
        model_write(32'h10, 32'hCAFE_F00D, 4'hF);
        checks++;
        if (to1 || to2 || ac != arc || data !== old_val) begin
            errors++;
            $display("FAIL same_edge_read: got %h (aw=%0d ar=%0d), required old value %h", data, ac, arc, old_val);
        end
        do_read(32'h10, data, rresp_v, s2, arc, rc, to2);
        checks++;
        if (to2 || data !== model_regs[4]) begin
            errors++;
            $display("FAIL after_collision_read: got %h, required %h", data, model_regs[4]);
        end
    endtask

    task automatic test_random();
        logic [1:0] resp; logic [31:0] addr, data, rd; logic [3:0] strb;
        int s, ac, wc, bc, rc, aw_off, w_off, sel, aw_exp, w_exp; bit to;
        for (int it = 0; it < 40; it++) begin
            @(posedge aclk); #1;
            cfg_awready_delay = 5'($urandom_range(0, 3));
            cfg_wready_delay  = 5'($urandom_range(0, 3));
            cfg_arready_delay = 5'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = 32'(4 * $urandom_range(0, 15));
            else if (sel == 7) addr = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
            else if (sel == 8) addr = 32'(64 + $urandom_range(0, 63));
            else               addr = $urandom() | 32'h100;
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom(); strb = 4'($urandom_range(0, 15));
                aw_off = $urandom_range(0, 3); w_off = $urandom_range(0, 3);
                do_write(addr, data, strb, aw_off, w_off, resp, s, ac, wc, bc, to);
                aw_exp = s + aw_off + int'(cfg_awready_delay);
                w_exp  = s + w_off + int'(cfg_wready_delay);
                checks++;
                if (to || resp !== model_resp(addr) || ac != aw_exp || wc != w_exp ||
                    bc != ((aw_exp > w_exp) ? aw_exp : w_exp) + 1) begin
                    errors++;
                    $display("FAIL rand_write[%0d] addr=%h: resp=%b aw=%0d w=%0d b=%0d, required resp=%b aw=%0d w=%0d",
                             it, addr, resp, ac - s, wc - s, bc - s, model_resp(addr), aw_exp - s, w_exp - s);
                end
                model_write(addr, data, strb);
            end else begin
                do_read(addr, rd, resp, s, ac, rc, to);
                checks++;
                if (to || resp !== model_resp(addr) || ac != s + int'(cfg_arready_delay) || rc != ac + 1 ||
                    rd !== ((model_resp(addr) == 2'b00) ? model_regs[addr[5:2]] : 32'h0)) begin
                    errors++;
                    $display("FAIL rand_read[%0d] addr=%h: data=%h resp=%b ar=%0d r=%0d, required resp=%b ar=%0d",
                             it, addr, rd, resp, ac - s, rc - s, model_resp(addr), cfg_arready_delay);
                end
            end
        end
        cfg_awready_delay = '0; cfg_wready_delay = '0; cfg_arready_delay = '0;
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic [31:0] data; int s, ac, rc; bit to;
        @(posedge aclk); #1;
        cfg_wready_delay = 5'd5;
        awaddr = 32'h14; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_setup: awready=%b wready=%b, required 1 0", awready, wready);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b1; wvalid = 1'b0; cfg_wready_delay = 5'd0;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready, bvalid} !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: rdy/bvalid=%b, required 0000", {awready, wready, arready, bvalid});
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            checks++;
            if (bvalid !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
                errors++;
                $display("FAIL mid_reset_after[%0d]: bvalid=%b rdy=%b, required 0 111",
                         i, bvalid, {awready, wready, arready});
            end
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), data, resp, s, ac, rc, to);
            checks++;
            if (to || data !== model_regs[i]) begin
                errors++;
                $display("FAIL mid_reset_regs[%0d]: got %h, required %h", i, data, model_regs[i]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_aw_delay();
        test_strobe();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_responder.md
Name: axi4_lite_slave_responder

Overview:
- Synthesizable AXI4-Lite slave (responder) backed by a word-addressed register file.
- Serves as the RTL DUT end of the bus that the master agent drives; the slave agent's behaviour is mirrored in hardware.
- Write and read channels are independent. Ready-delay is programmable per channel (the hardware counterpart of the delay structs in Axi4LiteGlobalsPkg).
- BRESP/RRESP are generated from address decode.

Parameters:
- ADDRESS_WIDTH, 32, address bus width (from Axi4LiteGlobalsPkg)
- DATA_WIDTH, 32, data bus width; DATA_WIDTH/8 strobe lanes
- DELAY_WIDTH, 5, width of ready-delay config inputs
- NUM_REGS, 16, number of DATA_WIDTH registers
- BASE_ADDR, 32'h0000_0000, byte address of register 0

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- awaddr  in  ADDRESS_WIDTH  write address
- awprot  in  3  write protection (accepted, ignored)
- awvalid  in  1;  awready  out  1
- wdata  in  DATA_WIDTH;  wstrb  in  DATA_WIDTH/8
- wvalid  in  1;  wready  out  1
- bresp  out  2;  bvalid  out  1;  bready  in  1
- araddr  in  ADDRESS_WIDTH;  arprot  in  3 (ignored)
- arvalid  in  1;  arready  out  1
- rdata  out  DATA_WIDTH;  rresp  out  2;  rvalid  out  1;  rready  in  1
- cfg_awready_delay  in  DELAY_WIDTH  cycles awvalid must be held before awready
- cfg_wready_delay  in  DELAY_WIDTH  same for W
- cfg_arready_delay  in  DELAY_WIDTH  same for AR

Behaviour:
- Reset (areset=1 at posedge):
  - All registers cleared to 0.
  - bvalid, rvalid = 0; bresp, rresp = 2'b00; rdata = 0.
  - Delay counters cleared; held flags cleared.
  - awready, wready and arready are forced 0 while areset is high.
  - Reset mid-transaction discards the transaction with no response.
- Ready generation (per channel):
  - cnt increments, saturating, each cycle valid=1 and ready=0; cleared on handshake.
  - ready = !areset && !held && (cnt >= cfg).
  - Ready does not depend on valid. Delay 0 means ready is high while idle, so the handshake occurs in the same cycle valid rises. Delay D means the handshake occurs D cycles after valid rises.
- Write FSM, states W_COLLECT and W_RESP:
  - W_COLLECT: AW handshake captures awaddr and sets aw_held; W handshake captures wdata/wstrb and sets w_held. The two may arrive in either order or in the same cycle.
  - When both are held, the next edge commits the write (only byte lanes with wstrb=1 are updated, and only when decode is OKAY), sets bvalid=1 with bresp, and moves to W_RESP.
  - W_RESP: awready and wready stay 0. bvalid and bresp are held stable until bready=1. On the handshake edge, bvalid=0, held flags clear, and the FSM returns to W_COLLECT. Minimum AW/W-to-B latency is 1 cycle.
- Read FSM, states R_IDLE and R_RESP:
  - An AR handshake in R_IDLE registers rdata and rresp at that edge and sets rvalid=1 the next cycle (latency 1).
  - arready is 0 in R_RESP. rdata, rresp and rvalid are held until rready=1. On the handshake edge, rvalid=0 and the FSM returns to R_IDLE.
  - rdata is 0 on error.
- Decode (shared by both paths):
  - offset = addr - BASE_ADDR.
  - addr < BASE_ADDR or offset>>2 >= NUM_REGS gives DECERR (2'b11).
  - Otherwise offset[1:0] != 0 gives SLVERR (2'b10).
  - Otherwise OKAY (2'b00). EXOKAY is never returned.
  - Errored writes do not modify any register.
- Simultaneous events:
  - A read capture and a write commit to the same register on the same edge return the old value.
  - Read and write channels progress concurrently, with no arbitration.
  - bvalid/rvalid never deassert without the corresponding ready.

Decomposition:
- Axi4LiteGlobalsPkg supplies ADDRESS_WIDTH, DATA_WIDTH, DELAY_WIDTH, brespEnum and rrespEnum. bresp/rresp are driven from these enum encodings.
- Add to the package:
  - a 2-bit decode-result typedef (DEC_OKAY, DEC_SLVERR, DEC_DECERR);
  - a writeFsmStateEnum;
  - a readFsmStateEnum.
- One sub-module, axi4_lite_ready_delay (counter plus ready logic: valid, held, cfg in; ready out), is instantiated three times.

Test Plan:
- All cfg delays=0. Write awaddr=0x4, wdata=0xDEADBEEF, wstrb=0xF, then read 0x4 -> AW and W handshakes in cycle 0; bvalid in cycle 1 with bresp=OKAY; rdata=0xDEADBEEF, rresp=OKAY, rvalid one cycle after AR handshake.
- cfg_awready_delay=3, cfg_wready_delay=0. W presented 2 cycles before AW -> wready handshakes immediately; awready rises exactly 3 cycles after awvalid; bvalid one cycle after the AW handshake.
- Register 0x8 = 0xFFFFFFFF. Write 0x8 with wdata=0x12345678, wstrb=0b0101, then read 0x8 -> rdata=0xFF34FF78.
- Write 0x40 (NUM_REGS=16) -> bresp=DECERR, no register changed. Read 0x6 -> rresp=SLVERR, rdata=0.
- Hold bready=0 for 5 cycles after bvalid -> bvalid and bresp stable; awready=wready=0 until the handshake. Same check for rready on the read path.
- Assert areset one cycle after an AW handshake with W pending -> bvalid stays 0, all registers read back 0 afterwards, readies return once areset drops.
